// File: rtl/vproc_elem_red.sv
// vproc_elem_red: multi-lane masked reduction unit for the vector element
// pipeline. Folds LANES elements per beat into a scalar accumulator, seeded by
// an initial value on the first beat, and returns the result through a
// single-entry valid/ready output register.
//
// Ports:
//   clk_i, async_rst_ni, sync_rst_ni   clock, async / sync active-low resets
//   in_valid_i / in_ready_o            input beat handshake
//   in_first_i / in_last_i             reduction framing
//   in_op_i, in_eew_i                  operation and element width (first beat)
//   in_init_i                          scalar seed (first beat)
//   in_elems_i, in_mask_i              lane elements and lane-active bits
//   in_xreg_i, in_vd_i                 destination selection (first beat)
//   out_valid_o / out_ready_i          result handshake
//   out_res_o, out_wmask_o             result and byte enables
//   out_xreg_valid_o, out_vd_o         xreg write strobe, destination vreg
//   out_active_o                       number of active elements folded
module vproc_elem_red #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  sync_rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_first_i,
    input  logic                  in_last_i,
    input  logic [2:0]            in_op_i,
    input  logic [1:0]            in_eew_i,
    input  logic [31:0]           in_init_i,
    input  logic [LANES*32-1:0]   in_elems_i,
    input  logic [LANES-1:0]      in_mask_i,
    input  logic                  in_xreg_i,
    input  logic [4:0]            in_vd_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_res_o,
    output logic [3:0]            out_wmask_o,
    output logic                  out_xreg_valid_o,
    output logic [4:0]            out_vd_o,
    output logic [CNT_W-1:0]      out_active_o
);

    typedef enum logic [2:0] {
        OP_SUM  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_MINU = 3'd4,
        OP_MIN  = 3'd5,
        OP_MAXU = 3'd6,
        OP_MAX  = 3'd7
    } op_e;

    // Zero everything above the element width.
    function automatic logic [31:0] trunc_eew(input logic [31:0] v, input logic [1:0] eew);
        case (eew)
            2'd0:    trunc_eew = {24'b0, v[7:0]};
            2'd1:    trunc_eew = {16'b0, v[15:0]};
            default: trunc_eew = v;
        endcase
    endfunction

    function automatic logic [31:0] sext_eew(input logic [31:0] v, input logic [1:0] eew);
        case (eew)
            2'd0:    sext_eew = {{24{v[7]}}, v[7:0]};
            2'd1:    sext_eew = {{16{v[15]}}, v[15:0]};
            default: sext_eew = v;
        endcase
    endfunction

    // One fold step; 'a' is the running value and wins every tie.
    function automatic logic [31:0] combine(input logic [31:0] a, input logic [31:0] b_raw,
                                            input op_e op, input logic [1:0] eew);
        logic [31:0] b;
        logic [31:0] r;
        b = trunc_eew(b_raw, eew);
        r = a;
        unique case (op)
            OP_SUM:  r = a + b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MINU: r = (b < a) ? b : a;
            OP_MIN:  r = ($signed(sext_eew(b, eew)) < $signed(sext_eew(a, eew))) ? b : a;
            OP_MAXU: r = (b > a) ? b : a;
            OP_MAX:  r = ($signed(sext_eew(b, eew)) > $signed(sext_eew(a, eew))) ? b : a;
        endcase
        return trunc_eew(r, eew);
    endfunction

    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    op_e              op_q;
    logic [1:0]       eew_q;
    logic             xreg_q;
    logic [4:0]       vd_q;
    logic             busy_q;

    logic [31:0]      res_q;
    logic             valid_q;
    logic [3:0]       wmask_q;
    logic             xreg_out_q;
    logic [4:0]       vd_out_q;
    logic [CNT_W-1:0] active_q;

    logic             start;
    op_e              op_eff;
    logic [1:0]       eew_eff;
    logic             xreg_eff;
    logic [4:0]       vd_eff;
    logic [31:0]      fold;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       wmask_next;
    logic             accept;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;

    // A beat arriving while idle starts a new reduction even without in_first_i.
    assign start    = in_first_i | ~busy_q;
    assign op_eff   = start ? op_e'(in_op_i) : op_q;
    assign eew_eff  = start ? in_eew_i : eew_q;
    assign xreg_eff = start ? in_xreg_i : xreg_q;
    assign vd_eff   = start ? in_vd_i : vd_q;

    always_comb begin
        fold = start ? trunc_eew(in_init_i, in_eew_i) : acc_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_mask_i[i]) begin
                fold = combine(fold, in_elems_i[32*i +: 32], op_eff, eew_eff);
            end
        end
    end

    // Extra top bit catches the overflow that triggers saturation.
    always_comb begin
        cnt_sum = start ? '0 : {1'b0, cnt_q};
        for (int unsigned i = 0; i < LANES; i++) begin
            cnt_sum = cnt_sum + {{CNT_W{1'b0}}, in_mask_i[i]};
        end
        cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        wmask_next = 4'b1111;
        if (xreg_eff) begin
            wmask_next = 4'b0000;
        end else if (eew_eff == 2'd0) begin
            wmask_next = 4'b0001;
        end else if (eew_eff == 2'd1) begin
            wmask_next = 4'b0011;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            op_q       <= OP_SUM;
            eew_q      <= '0;
            xreg_q     <= 1'b0;
            vd_q       <= '0;
            busy_q     <= 1'b0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            wmask_q    <= '0;
            xreg_out_q <= 1'b0;
            vd_out_q   <= '0;
            active_q   <= '0;
        end else if (!sync_rst_ni) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            op_q       <= OP_SUM;
            eew_q      <= '0;
            xreg_q     <= 1'b0;
            vd_q       <= '0;
            busy_q     <= 1'b0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            wmask_q    <= '0;
            xreg_out_q <= 1'b0;
            vd_out_q   <= '0;
            active_q   <= '0;
        end else begin
            if (valid_q && out_ready_i) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                if (in_last_i) begin
                    // Overrides the drain above when both happen in one cycle.
                    res_q      <= fold;
                    valid_q    <= 1'b1;
                    wmask_q    <= wmask_next;
                    xreg_out_q <= xreg_eff;
                    vd_out_q   <= vd_eff;
                    active_q   <= cnt_next;
                    busy_q     <= 1'b0;
                end else begin
                    acc_q  <= fold;
                    cnt_q  <= cnt_next;
                    op_q   <= op_eff;
                    eew_q  <= eew_eff;
                    xreg_q <= xreg_eff;
                    vd_q   <= vd_eff;
                    busy_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid_o      = valid_q;
    assign out_res_o        = res_q;
    assign out_wmask_o      = wmask_q;
    assign out_xreg_valid_o = valid_q & xreg_out_q;
    assign out_vd_o         = vd_out_q;
    assign out_active_o     = active_q;

endmodule

// File: tb/tb_vproc_elem_red.sv
// tb_vproc_elem_red: scoreboard bench for vproc_elem_red (LANES=4, CNT_W=16).
// Expected results are queued when the last beat is driven and compared when
// the output handshake completes.
module tb_vproc_elem_red;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 16;

    logic                clk = 1'b0;
    logic                async_rst_n = 1'b0;
    logic                sync_rst_n = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_first = 1'b0;
    logic                in_last = 1'b0;
    logic [2:0]          in_op = '0;
    logic [1:0]          in_eew = '0;
    logic [31:0]         in_init = '0;
    logic [LANES*32-1:0] in_elems = '0;
    logic [LANES-1:0]    in_mask = '0;
    logic                in_xreg = 1'b0;
    logic [4:0]          in_vd = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [31:0]         out_res;
    logic [3:0]          out_wmask;
    logic                out_xreg_valid;
    logic [4:0]          out_vd;
    logic [CNT_W-1:0]    out_active;

    vproc_elem_red #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .async_rst_ni     (async_rst_n),
        .sync_rst_ni      (sync_rst_n),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_first_i       (in_first),
        .in_last_i        (in_last),
        .in_op_i          (in_op),
        .in_eew_i         (in_eew),
        .in_init_i        (in_init),
        .in_elems_i       (in_elems),
        .in_mask_i        (in_mask),
        .in_xreg_i        (in_xreg),
        .in_vd_i          (in_vd),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_res_o        (out_res),
        .out_wmask_o      (out_wmask),
        .out_xreg_valid_o (out_xreg_valid),
        .out_vd_o         (out_vd),
        .out_active_o     (out_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  wm;
        logic        xv;
        logic [4:0]  vd;
        logic [15:0] act;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [3:0] wm, input logic xv,
                        input logic [4:0] vd, input logic [15:0] act);
        exp_t e;
        e.res = res; e.wm = wm; e.xv = xv; e.vd = vd; e.act = act;
        q.push_back(e);
    endtask

    // Output monitor: compares on every completed handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res", out_res, e.res);
                chk("wmask", {28'b0, out_wmask}, {28'b0, e.wm});
                chk("xreg_valid", {31'b0, out_xreg_valid}, {31'b0, e.xv});
                chk("vd", {27'b0, out_vd}, {27'b0, e.vd});
                chk("active", {16'b0, out_active}, {16'b0, e.act});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic beat(input logic f, input logic l, input logic [2:0] op, input logic [1:0] eew,
                        input logic [31:0] init, input logic [LANES*32-1:0] el,
                        input logic [LANES-1:0] m, input logic x, input logic [4:0] vd);
        int n;
        in_first = f; in_last = l; in_op = op; in_eew = eew; in_init = init;
        in_elems = el; in_mask = m; in_xreg = x; in_vd = vd; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    logic [31:0] snap;
    logic [31:0] s;
    logic [15:0] c;
    logic [LANES*32-1:0] el;
    logic [LANES-1:0] m;

    initial begin
        #12;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_xv", {31'b0, out_xreg_valid}, 32'd0);
        chk("rst_res", out_res, 32'd0);
        chk("rst_wmask", {28'b0, out_wmask}, 32'd0);
        chk("rst_vd", {27'b0, out_vd}, 32'd0);
        chk("rst_active", {16'b0, out_active}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        async_rst_n = 1'b1;
        @(posedge clk); #1;

        // SUM EEW32 single beat
        push(32'd20, 4'b1111, 1'b0, 5'd3, 16'd4);
        beat(1, 1, 3'd0, 2'd2, 32'd10, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 0, 5'd3);

        // MINU EEW8 two beats, garbage in upper element bits
        beat(1, 0, 3'd4, 2'd0, 32'hABCD_0040,
             {32'hFFFF_FF80, 32'h1234_5605, 32'h0000_0103, 32'hDEAD_BE90}, 4'b1011, 0, 5'd7);
        push(32'h03, 4'b0001, 1'b0, 5'd7, 16'd3);
        beat(0, 1, 3'd0, 2'd2, 32'hFFFF_FFFF, {4{32'h01}}, 4'b0000, 1, 5'd9);

        // SUM EEW8 wrap
        push(32'h00, 4'b0001, 1'b0, 5'd1, 16'd1);
        beat(1, 1, 3'd0, 2'd0, 32'hFF, {32'h55, 32'h55, 32'h55, 32'h01}, 4'b0001, 0, 5'd1);

        // MAX EEW16 signed
        push(32'h7FFF, 4'b0011, 1'b0, 5'd2, 16'd1);
        beat(1, 1, 3'd7, 2'd1, 32'h7FFF, {32'h0, 32'h0, 32'h0, 32'h8000}, 4'b0001, 0, 5'd2);

        // MIN EEW8 signed, AND/OR, MAXU
        push(32'hF0, 4'b0001, 1'b0, 5'd4, 16'd2);
        beat(1, 1, 3'd5, 2'd0, 32'h10, {32'h0, 32'h0, 32'h20, 32'hF0}, 4'b0011, 0, 5'd4);
        push(32'h0F00, 4'b0011, 1'b0, 5'd5, 16'd2);
        beat(1, 1, 3'd1, 2'd1, 32'hFFFF, {32'h0, 32'h0, 32'hFF00, 32'h0F0F}, 4'b0011, 0, 5'd5);
        push(32'h0F, 4'b1111, 1'b0, 5'd6, 16'd4);
        beat(1, 1, 3'd2, 2'd2, 32'h0, {32'd8, 32'd4, 32'd2, 32'd1}, 4'b1111, 0, 5'd6);
        push(32'h8000, 4'b0011, 1'b0, 5'd8, 16'd2);
        beat(1, 1, 3'd6, 2'd1, 32'h0001, {32'h0, 32'h0, 32'h7FFF, 32'h8000}, 4'b0011, 0, 5'd8);

        // Empty XOR reduction to xreg
        push(32'h1234, 4'b0000, 1'b1, 5'd10, 16'd0);
        beat(1, 1, 3'd3, 2'd2, 32'h1234, {4{32'hFFFF_FFFF}}, 4'b0000, 1, 5'd10);

        // Non-first beat while idle starts a reduction
        push(32'd11, 4'b1111, 1'b0, 5'd11, 16'd4);
        beat(0, 1, 3'd0, 2'd2, 32'd7, {4{32'd1}}, 4'b1111, 0, 5'd11);

        // Restart while busy discards partial
        beat(1, 0, 3'd0, 2'd2, 32'd100, {4{32'd50}}, 4'b1111, 0, 5'd12);
        push(32'd9, 4'b1111, 1'b0, 5'd13, 16'd4);
        beat(1, 1, 3'd0, 2'd2, 32'd5, {4{32'd1}}, 4'b1111, 0, 5'd13);
        wait_drain();

        // Backpressure: stalled result, stalled beat, then back-to-back release
        out_ready = 1'b0;
        push(32'd26, 4'b1111, 1'b0, 5'd14, 16'd4);
        beat(1, 1, 3'd0, 2'd2, 32'd16, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 0, 5'd14);
        snap = out_res;
        push(32'h0A, 4'b0001, 1'b0, 5'd15, 16'd2);
        in_first = 1; in_last = 1; in_op = 3'd0; in_eew = 2'd0; in_init = 32'd2;
        in_elems = {32'h0, 32'h0, 32'd3, 32'd5}; in_mask = 4'b0011; in_xreg = 0; in_vd = 5'd15;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_res", out_res, snap);
            chk("stall_vd", {27'b0, out_vd}, 32'd14);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // Async reset mid-reduction
        beat(1, 0, 3'd0, 2'd2, 32'd100, {4{32'd9}}, 4'b1111, 0, 5'd16);
        async_rst_n = 1'b0; #2;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        async_rst_n = 1'b1;
        @(posedge clk); #1;
        push(32'd13, 4'b1111, 1'b0, 5'd17, 16'd3);
        beat(1, 1, 3'd0, 2'd2, 32'd10, {32'd0, 32'd1, 32'd1, 32'd1}, 4'b0111, 0, 5'd17);

        // Sync reset mid-reduction; following non-first beat must start fresh
        beat(1, 0, 3'd0, 2'd2, 32'd100, {4{32'd9}}, 4'b1111, 0, 5'd18);
        sync_rst_n = 1'b0;
        @(posedge clk); #1;
        sync_rst_n = 1'b1;
        push(32'd3, 4'b1111, 1'b0, 5'd19, 16'd1);
        beat(0, 1, 3'd0, 2'd2, 32'd1, {32'd0, 32'd0, 32'd0, 32'd2}, 4'b0001, 0, 5'd19);

        // Random multi-beat SUM EEW32, one beat per cycle
        for (int r = 0; r < 4; r++) begin
            int nb;
            nb = $urandom_range(1, 3);
            s = $urandom;
            c = 0;
            for (int b = 0; b < nb; b++) begin
                logic [31:0] init;
                init = s;
                for (int i = 0; i < LANES; i++) el[32*i +: 32] = $urandom;
                m = 4'($urandom_range(0, 15));
                for (int i = 0; i < LANES; i++) begin
                    if (m[i]) begin
                        s = s + el[32*i +: 32];
                        c = c + 16'd1;
                    end
                end
                if (b == nb - 1) push(s, 4'b1111, 1'b0, 5'(20 + r), c);
                beat(b == 0, b == nb - 1, 3'd0, 2'd2, init, el, m, 0, 5'(20 + r));
            end
        end

        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vproc_elem_red.md
# vproc_elem_red

Parametrised multi-lane reduction unit for the vector element pipeline. Each beat carries LANES elements with per-lane v0 mask bits, and masked elements are fully supported. The unit folds a reduction over any number of beats into one scalar, seeded by an initial value. It returns the scalar through a buffered valid/ready output, either to element 0 of vd or to an xreg. It sits after the operand fetch stage beside the ELEM unit and takes over its unmasked-only reduction path.

## Interface
Parameters:
- LANES, 4, elements per input beat; legal values 1, 2, 4, 8.
- CNT_W, 16, width of the active-element counter; saturates at its maximum.

Ports:
- clk_i  in  1  clock.
- async_rst_ni  in  1  reset, asynchronous, active-low.
- sync_rst_ni  in  1  synchronous reset, active-low; same effect as async reset.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o.
- in_first_i  in  1  first beat of a reduction.
- in_last_i  in  1  last beat of a reduction.
- in_op_i  in  3  0 SUM, 1 AND, 2 OR, 3 XOR, 4 MINU, 5 MIN, 6 MAXU, 7 MAX.
- in_eew_i  in  2  0 = 8 bit, 1 = 16 bit, 2 = 32 bit; 3 is illegal.
- in_init_i  in  32  scalar seed (vs1[0]); sampled on the first beat only.
- in_elems_i  in  LANES*32  lane i at bits [32i+31:32i]; only the low EEW bits are used.
- in_mask_i  in  LANES  lane active when set (already merged with vl and v0).
- in_xreg_i  in  1  result goes to xreg instead of vreg; sampled on the first beat.
- in_vd_i  in  5  destination register address; sampled on the first beat.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer ready.
- out_res_o  out  32  reduced value in the low EEW bits; bits above EEW are zero.
- out_wmask_o  out  4  byte enables: 0001 / 0011 / 1111 for EEW 8 / 16 / 32; 0000 when xreg.
- out_xreg_valid_o  out  1  out_valid_o & xreg flag.
- out_vd_o  out  5  latched vd.
- out_active_o  out  CNT_W  number of active elements folded into the result.

## Operation
- State: acc_q[31:0], cnt_q, op_q, eew_q, xreg_q, vd_q, busy_q, and the output register (res_q, valid_q, meta).
- Base for a beat:
  - in_first_i, or busy_q = 0: base = in_init_i truncated to EEW; latch op, eew, xreg, vd; reset cnt to 0.
  - Otherwise: base = acc_q. A non-first beat while idle is treated as first.
  - in_first_i while busy_q = 1 discards the partial result and restarts.
- Fold: lanes 0..LANES-1 are combined sequentially into the base. An inactive lane passes the value through unchanged.
- Arithmetic, all on the low EEW bits:
  - SUM wraps modulo 2^EEW.
  - MIN/MAX compare EEW-bit signed values; MINU/MAXU compare unsigned.
  - On a tie, the accumulator is kept.
- Counter: cnt += popcount(in_mask_i) per beat, saturating at 2^CNT_W-1.
- Beat without in_last_i: acc_q is updated and busy_q is set.
- Beat with in_last_i: the folded value goes to res_q (upper bits zeroed), meta and count are copied, valid_q is set, and busy_q is cleared.
- Empty reduction (all beats masked): the result equals init truncated to EEW; out_active_o = 0; the write is still performed.
- op/eew/xreg/vd are taken from the first beat; values on later beats are ignored.

## Timing
- Reset values: out_valid_o 0, out_xreg_valid_o 0, out_res_o 0, out_wmask_o 0, out_vd_o 0, out_active_o 0, in_ready_o 1. Internal state: busy_q 0, cnt_q 0.
- in_ready_o = ~valid_q | out_ready_i. Purely combinational, with no path from in_valid_i.
- Latency: result valid in the cycle after the last beat is accepted. Throughput is one beat per cycle.
- Back-to-back reductions are allowed. A last beat accepted in the same cycle as the output handshake replaces the output register without a bubble.
- Output stability: while out_valid_o & ~out_ready_i, all out_* stay stable and input beats are stalled, including non-last beats.
- Reset, async or sync, mid-reduction drops the partial accumulator and any pending result. No output is produced for that reduction.
- Only acc_q and the output register depend on in_elems_i. The combinational fold is LANES deep and must close timing at LANES = 8.

## Test plan
- SUM, EEW32, LANES=4, one beat (first & last), elems {1,2,3,4}, mask 1111, init 10 -> next cycle out_res_o 20, out_wmask_o 1111, out_active_o 4.
- MINU, EEW8, two beats: elems {0x80,0x05,0x03,0x90} mask 1011, then {0x01,...} mask 0000, init 0x40 -> res 0x03, active 3, upper 24 bits 0.
- SUM, EEW8 wrap: init 0xFF, elem 0x01 in lane 0 only -> res 0x00. MAX, EEW16: init 0x7FFF, elem 0x8000 -> res 0x7FFF.
- Backpressure: hold out_ready_i 0 for 3 cycles after a result -> in_ready_o 0, outputs stable. Then a second reduction issued back-to-back after release -> both results emitted in order with no lost beats.
- All lanes masked, in_xreg_i 1, XOR, init 0x1234 -> res 0x1234, out_xreg_valid_o 1, out_wmask_o 0000, active 0.
- Restart and reset:
  - First beat issued while busy -> the earlier partial result is discarded.
  - async_rst_ni pulsed mid-reduction -> no output; the next reduction is correct from its init.
